// File: rtl/urv_rf_write_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package urv_rf_write_sched_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_WAIT = 2'd1,
        DBG_ACK  = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/urv_rf_scoreboard.sv
// Pending-write scoreboard for divider destinations; x0 is never pending.
module urv_rf_scoreboard
    import urv_rf_write_sched_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     hazard
);

    logic [31:0] pending;

    // A set to the same index as a simultaneous clear takes precedence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && (set_idx == reg_idx_t'(i)))
                    pending[i] <= 1'b1;
                else if (clr_en && (clr_idx == reg_idx_t'(i)))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign hazard = ((rs1 != '0) && pending[rs1]) ||
                    ((rs2 != '0) && pending[rs2]) ||
                    ((rd  != '0) && pending[rd]);

endmodule

// File: rtl/urv_rf_write_sched.sv
// Arbitrates the single register-file write port between pipeline, divider and debug,
// and tracks divider hazards and starvation.
module urv_rf_write_sched
    import urv_rf_write_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  w_rd_i,
    input  logic [31:0] w_rd_value_i,
    input  logic        w_rd_store_i,
    input  logic        div_issue_i,
    input  logic [4:0]  div_rd_i,
    input  logic        div_valid_i,
    input  logic [31:0] div_value_i,
    output logic        div_ready_o,
    input  logic        dbg_req_i,
    input  logic [4:0]  dbg_rd_i,
    input  logic [31:0] dbg_value_i,
    output logic        dbg_ack_o,
    input  logic [4:0]  d_rs1_i,
    input  logic [4:0]  d_rs2_i,
    input  logic [4:0]  d_rd_i,
    input  logic        d_is_div_i,
    output logic        d_stall_o,
    output logic        x_stall_req_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o
);

    logic       div_busy;
    reg_idx_t   div_rd;
    logic [2:0] starve_cnt;
    dbg_state_e dbg_state;
    logic       dbg_ack_q;
    logic       div_ready;
    logic       dbg_grant;
    logic       sb_hazard;

    assign div_ready = div_valid_i & ~w_rd_store_i & div_busy;
    assign dbg_grant = (dbg_state == DBG_WAIT) & dbg_req_i & ~w_rd_store_i & ~div_ready;

    // A new issue in the same cycle as the old result retires keeps the divider busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_busy <= 1'b0;
            div_rd   <= '0;
        end else if (div_issue_i) begin
            div_busy <= 1'b1;
            div_rd   <= div_rd_i;
        end else if (div_ready) begin
            div_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            starve_cnt <= '0;
        else if (div_ready)
            starve_cnt <= '0;
        else if (div_valid_i && (starve_cnt != 3'd7))
            starve_cnt <= starve_cnt + 3'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dbg_state <= DBG_IDLE;
            dbg_ack_q <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (dbg_state)
                DBG_IDLE: if (dbg_req_i) dbg_state <= DBG_WAIT;
                DBG_WAIT: begin
                    if (!dbg_req_i) begin
                        dbg_state <= DBG_IDLE;
                    end else if (dbg_grant) begin
                        dbg_state <= DBG_ACK;
                        dbg_ack_q <= 1'b1;
                    end
                end
                DBG_ACK:  dbg_state <= DBG_IDLE;
                default:  dbg_state <= DBG_IDLE;
            endcase
        end
    end

    urv_rf_scoreboard u_scoreboard (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_en  (div_issue_i && (div_rd_i != '0)),
        .set_idx (div_rd_i),
        .clr_en  (div_ready),
        .clr_idx (div_rd),
        .rs1     (d_rs1_i),
        .rs2     (d_rs2_i),
        .rd      (d_rd_i),
        .hazard  (sb_hazard)
    );

    // Writes to x0 never raise the strobe; outputs are forced quiet while reset is held.
    always_comb begin
        rf_rd_o       = '0;
        rf_rd_value_o = '0;
        rf_rd_store_o = 1'b0;
        if (!rst_i) begin
            if (w_rd_store_i) begin
                rf_rd_o       = w_rd_i;
                rf_rd_value_o = w_rd_value_i;
                rf_rd_store_o = (w_rd_i != '0);
            end else if (div_ready) begin
                if (div_rd != '0) begin
                    rf_rd_o       = div_rd;
                    rf_rd_value_o = div_value_i;
                    rf_rd_store_o = 1'b1;
                end
            end else if (dbg_grant && (dbg_rd_i != '0)) begin
                rf_rd_o       = dbg_rd_i;
                rf_rd_value_o = dbg_value_i;
                rf_rd_store_o = 1'b1;
            end
        end
    end

    assign div_ready_o   = div_ready & ~rst_i;
    assign dbg_ack_o     = dbg_ack_q & ~rst_i;
    assign d_stall_o     = ~rst_i & (sb_hazard | (d_is_div_i & div_busy & ~div_ready));
    assign x_stall_req_o = ~rst_i & (int'(starve_cnt) >= STARVE_LIMIT);

endmodule

// File: tb/tb_urv_rf_write_sched.sv
// Directed self-checking bench for the register-file write scheduler.
module tb_urv_rf_write_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  w_rd_i;
    logic [31:0] w_rd_value_i;
    logic        w_rd_store_i;
    logic        div_issue_i;
    logic [4:0]  div_rd_i;
    logic        div_valid_i;
    logic [31:0] div_value_i;
    logic        div_ready_o;
    logic        dbg_req_i;
    logic [4:0]  dbg_rd_i;
    logic [31:0] dbg_value_i;
    logic        dbg_ack_o;
    logic [4:0]  d_rs1_i;
    logic [4:0]  d_rs2_i;
    logic [4:0]  d_rd_i;
    logic        d_is_div_i;
    logic        d_stall_o;
    logic        x_stall_req_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_store_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    urv_rf_write_sched #(.STARVE_LIMIT(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .w_rd_i        (w_rd_i),
        .w_rd_value_i  (w_rd_value_i),
        .w_rd_store_i  (w_rd_store_i),
        .div_issue_i   (div_issue_i),
        .div_rd_i      (div_rd_i),
        .div_valid_i   (div_valid_i),
        .div_value_i   (div_value_i),
        .div_ready_o   (div_ready_o),
        .dbg_req_i     (dbg_req_i),
        .dbg_rd_i      (dbg_rd_i),
        .dbg_value_i   (dbg_value_i),
        .dbg_ack_o     (dbg_ack_o),
        .d_rs1_i       (d_rs1_i),
        .d_rs2_i       (d_rs2_i),
        .d_rd_i        (d_rd_i),
        .d_is_div_i    (d_is_div_i),
        .d_stall_o     (d_stall_o),
        .x_stall_req_o (x_stall_req_o),
        .rf_rd_o       (rf_rd_o),
        .rf_rd_value_o (rf_rd_value_o),
        .rf_rd_store_o (rf_rd_store_o)
    );

    // Start a new cycle; inputs set by the caller afterwards belong to that cycle.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic [4:0] rd, input logic [31:0] val, input logic st);
        checkOutput({tag, "_rd"},    32'(rf_rd_o),       32'(rd));
        checkOutput({tag, "_val"},   rf_rd_value_o,      val);
        checkOutput({tag, "_store"}, 32'(rf_rd_store_o), 32'(st));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        w_rd_i = '0; w_rd_value_i = '0; w_rd_store_i = 1'b0;
        div_issue_i = 1'b0; div_rd_i = '0; div_valid_i = 1'b0; div_value_i = '0;
        dbg_req_i = 1'b0; dbg_rd_i = '0; dbg_value_i = '0;
        d_rs1_i = '0; d_rs2_i = '0; d_rd_i = '0; d_is_div_i = 1'b0;

        // Reset: outputs quiet even with a pipeline write presented.
        applyStimulus();
        applyStimulus();
        w_rd_store_i = 1'b1; w_rd_i = 5'd3; w_rd_value_i = 32'hFFFF;
        #2;
        checkWrite("rst_pipe", 5'd0, 32'h0, 1'b0);
        checkOutput("rst_stall", 32'(d_stall_o), 32'd0);
        checkOutput("rst_ack", 32'(dbg_ack_o), 32'd0);
        checkOutput("rst_xstall", 32'(x_stall_req_o), 32'd0);

        // Pipeline pass-through.
        applyStimulus();
        rst_i = 1'b0; w_rd_i = 5'd2; w_rd_value_i = 32'hCAFE;
        #2;
        checkWrite("pipe", 5'd2, 32'hCAFE, 1'b1);

        // Divide to x5: hazard, writeback, hazard clears.
        applyStimulus();
        w_rd_store_i = 1'b0; w_rd_i = '0; w_rd_value_i = '0;
        div_issue_i = 1'b1; div_rd_i = 5'd5;
        #2;
        checkOutput("s1_nostall", 32'(d_stall_o), 32'd0);
        checkWrite("s1_idle", 5'd0, 32'h0, 1'b0);
        applyStimulus();
        div_issue_i = 1'b0; d_rs1_i = 5'd5;
        #2;
        checkOutput("s1_raw", 32'(d_stall_o), 32'd1);
        applyStimulus();
        d_rs1_i = 5'd0; d_rs2_i = 5'd5; div_valid_i = 1'b1; div_value_i = 32'h1234;
        #2;
        checkOutput("s1_ready", 32'(div_ready_o), 32'd1);
        checkWrite("s1_div", 5'd5, 32'h1234, 1'b1);
        applyStimulus();
        div_valid_i = 1'b0; div_value_i = '0;
        #2;
        checkOutput("s1_cleared", 32'(d_stall_o), 32'd0);
        checkOutput("s1_noready", 32'(div_ready_o), 32'd0);
        d_rs2_i = '0;

        // Starvation: 4 denied cycles then grant.
        applyStimulus();
        div_issue_i = 1'b1; div_rd_i = 5'd6;
        applyStimulus();
        div_issue_i = 1'b0; div_valid_i = 1'b1; div_value_i = 32'h6666;
        w_rd_store_i = 1'b1; w_rd_i = 5'd2; w_rd_value_i = 32'h55;
        #2;
        checkWrite("s2_pipe", 5'd2, 32'h55, 1'b1);
        checkOutput("s2_denied", 32'(div_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus();
        #2;
        checkOutput("s2_xstall4", 32'(x_stall_req_o), 32'd0);
        applyStimulus();
        w_rd_store_i = 1'b0; w_rd_i = '0; w_rd_value_i = '0;
        #2;
        checkOutput("s2_xstall5", 32'(x_stall_req_o), 32'd1);
        checkOutput("s2_grant", 32'(div_ready_o), 32'd1);
        checkWrite("s2_div", 5'd6, 32'h6666, 1'b1);
        applyStimulus();
        div_valid_i = 1'b0; div_value_i = '0;
        #2;
        checkOutput("s2_xstall_off", 32'(x_stall_req_o), 32'd0);

        // Three-way contention: pipe, then divider, then debug.
        applyStimulus();
        div_issue_i = 1'b1; div_rd_i = 5'd8;
        applyStimulus();
        div_issue_i = 1'b0;
        w_rd_store_i = 1'b1; w_rd_i = 5'd3; w_rd_value_i = 32'hA;
        div_valid_i = 1'b1; div_value_i = 32'h77;
        dbg_req_i = 1'b1; dbg_rd_i = 5'd4; dbg_value_i = 32'hDB;
        #2;
        checkWrite("s3_pipe", 5'd3, 32'hA, 1'b1);
        checkOutput("s3_ack0", 32'(dbg_ack_o), 32'd0);
        applyStimulus();
        w_rd_store_i = 1'b0; w_rd_i = '0; w_rd_value_i = '0;
        #2;
        checkWrite("s3_div", 5'd8, 32'h77, 1'b1);
        checkOutput("s3_ack1", 32'(dbg_ack_o), 32'd0);
        applyStimulus();
        div_valid_i = 1'b0; div_value_i = '0;
        #2;
        checkWrite("s3_dbg", 5'd4, 32'hDB, 1'b1);
        checkOutput("s3_ack2", 32'(dbg_ack_o), 32'd0);
        applyStimulus();
        #2;
        checkOutput("s3_ack3", 32'(dbg_ack_o), 32'd1);
        checkWrite("s3_quiet", 5'd0, 32'h0, 1'b0);
        dbg_req_i = 1'b0;
        applyStimulus();
        #2;
        checkOutput("s3_ack4", 32'(dbg_ack_o), 32'd0);

        // Debug write to x0: ack but no strobe.
        applyStimulus();
        dbg_req_i = 1'b1; dbg_rd_i = 5'd0; dbg_value_i = 32'h99;
        #2;
        checkOutput("s4_store0", 32'(rf_rd_store_o), 32'd0);
        applyStimulus();
        #2;
        checkWrite("s4_grant", 5'd0, 32'h0, 1'b0);
        applyStimulus();
        #2;
        checkOutput("s4_ack", 32'(dbg_ack_o), 32'd1);
        checkOutput("s4_store2", 32'(rf_rd_store_o), 32'd0);
        dbg_req_i = 1'b0;
        applyStimulus();
        #2;
        checkOutput("s4_ack_off", 32'(dbg_ack_o), 32'd0);

        // Debug request withdrawn while waiting: no write, no ack.
        applyStimulus();
        dbg_req_i = 1'b1; dbg_rd_i = 5'd10; dbg_value_i = 32'h10;
        applyStimulus();
        w_rd_store_i = 1'b1; w_rd_i = 5'd1; w_rd_value_i = 32'h1;
        #2;
        checkWrite("s4b_pipe", 5'd1, 32'h1, 1'b1);
        applyStimulus();
        w_rd_store_i = 1'b0; w_rd_i = '0; w_rd_value_i = '0; dbg_req_i = 1'b0;
        #2;
        checkOutput("s4b_nowrite", 32'(rf_rd_store_o), 32'd0);
        applyStimulus();
        #2;
        checkOutput("s4b_noack", 32'(dbg_ack_o), 32'd0);

        // Reset mid-divide with a debug request waiting.
        applyStimulus();
        div_issue_i = 1'b1; div_rd_i = 5'd7;
        applyStimulus();
        div_issue_i = 1'b0; d_rs1_i = 5'd7; d_is_div_i = 1'b1;
        dbg_req_i = 1'b1; dbg_rd_i = 5'd11; dbg_value_i = 32'hB;
        #2;
        checkOutput("s5_stall", 32'(d_stall_o), 32'd1);
        applyStimulus();
        rst_i = 1'b1; div_valid_i = 1'b1; div_value_i = 32'h5;
        #2;
        checkOutput("s5_rst_ready", 32'(div_ready_o), 32'd0);
        checkOutput("s5_rst_stall", 32'(d_stall_o), 32'd0);
        checkOutput("s5_rst_store", 32'(rf_rd_store_o), 32'd0);
        applyStimulus();
        rst_i = 1'b0; dbg_req_i = 1'b0;
        #2;
        checkOutput("s5_ready_dropped", 32'(div_ready_o), 32'd0);
        checkOutput("s5_pending_clr", 32'(d_stall_o), 32'd0);
        applyStimulus();
        div_valid_i = 1'b0; div_value_i = '0; d_rs1_i = '0; d_is_div_i = 1'b0;
        dbg_req_i = 1'b1; dbg_rd_i = 5'd12; dbg_value_i = 32'hC;
        #2;
        checkOutput("s5_fsm_idle", 32'(rf_rd_store_o), 32'd0);
        applyStimulus();
        #2;
        checkWrite("s5_dbg", 5'd12, 32'hC, 1'b1);
        applyStimulus();
        #2;
        checkOutput("s5_ack", 32'(dbg_ack_o), 32'd1);
        dbg_req_i = 1'b0;

        // Clear of x9 coincides with a new issue to x9.
        applyStimulus();
        div_issue_i = 1'b1; div_rd_i = 5'd9;
        applyStimulus();
        div_valid_i = 1'b1; div_value_i = 32'h99;
        #2;
        checkOutput("s6_ready", 32'(div_ready_o), 32'd1);
        checkWrite("s6_div", 5'd9, 32'h99, 1'b1);
        applyStimulus();
        div_issue_i = 1'b0; div_valid_i = 1'b0; div_value_i = '0; d_rs1_i = 5'd9;
        #2;
        checkOutput("s6_still_pending", 32'(d_stall_o), 32'd1);
        d_rs1_i = '0; d_is_div_i = 1'b1;
        #1;
        checkOutput("s6_busy_div", 32'(d_stall_o), 32'd1);
        d_is_div_i = 1'b0; d_rd_i = 5'd9;
        applyStimulus();
        div_valid_i = 1'b1; div_value_i = 32'h3;
        #2;
        checkWrite("s6_div2", 5'd9, 32'h3, 1'b1);
        applyStimulus();
        div_valid_i = 1'b0; div_value_i = '0;
        #2;
        checkOutput("s6_cleared", 32'(d_stall_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
